// File: rtl/seq_alu.sv
// seq_alu: registered execute-stage ALU with a valid/ready request side.
// Single-cycle integer ops complete one cycle after accept. When the macro
// SEQ_ALU_MULDIV_EN is defined, MUL/MULHU use an iterative radix-2
// shift-add multiplier and DIVU/REMU an iterative restoring divider, each
// taking DATA_WIDTH iterations while in_ready_o is held low. Without the
// macro no multiply/divide hardware exists: op codes 10-13 complete as
// single-cycle ops returning zero and in_ready_o is tied high.
module seq_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] ALUop1,
    input  logic [DATA_WIDTH-1:0] ALUop2,
    input  logic [3:0]            ALUctrl,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] ALUOut,
    output logic                  zero_o
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH < 4) begin : g_bad_width
        $error("seq_alu: DATA_WIDTH must be at least 4");
    end
    if (CNT_WIDTH < $clog2(DATA_WIDTH) + 1) begin : g_bad_cnt
        $error("seq_alu: CNT_WIDTH too small to hold DATA_WIDTH");
    end

    logic                  accept;
    logic                  single_accept;
    logic [SH_W-1:0]       shamt;
    logic [DATA_WIDTH-1:0] single_result;

    // Only the low log2(DATA_WIDTH) bits of operand B select the shift.
    assign shamt  = ALUop2[SH_W-1:0];
    assign accept = in_valid_i && in_ready_o;

    // Result of every op that completes in the cycle after accept.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // single_result unassigned, which would otherwise infer a latch.
        single_result = ALUop1 + ALUop2;
        case (ALUctrl)
            OP_ADD:   single_result = ALUop1 + ALUop2;
            OP_SUB:   single_result = ALUop1 - ALUop2;
            OP_AND:   single_result = ALUop1 & ALUop2;
            OP_OR:    single_result = ALUop1 | ALUop2;
            OP_XOR:   single_result = ALUop1 ^ ALUop2;
            OP_SLT:   single_result = {{(DATA_WIDTH-1){1'b0}},
                                       ($signed(ALUop1) < $signed(ALUop2))};
            OP_SLTU:  single_result = {{(DATA_WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
            OP_SLL:   single_result = ALUop1 << shamt;
            OP_SRL:   single_result = ALUop1 >> shamt;
            OP_SRA:   single_result = $unsigned($signed(ALUop1) >>> shamt);
            // Multiplies never finish here when the iterative unit exists.
            OP_MUL,
            OP_MULHU: single_result = '0;
`ifdef SEQ_ALU_MULDIV_EN
            // Reached only for a zero divisor: quotient saturates to all-ones
            // and the remainder is the dividend.
            OP_DIVU:  single_result = '1;
            OP_REMU:  single_result = ALUop1;
`else
            OP_DIVU,
            OP_REMU:  single_result = '0;
`endif
            default:  single_result = ALUop1 + ALUop2;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  cnt;
    // Multiply: {acc_hi, acc_lo} is the 2*DATA_WIDTH product/multiplier
    // register. Divide: acc_hi is the partial remainder, acc_lo shifts the
    // dividend out and the quotient in.
    logic [DATA_WIDTH-1:0] acc_hi;
    logic [DATA_WIDTH-1:0] acc_lo;
    logic [DATA_WIDTH-1:0] opb;      // multiplicand or divisor
    logic                  want_hi;  // MULHU/REMU return the high half

    logic                  is_mul_op;
    logic                  is_div_op;
    logic                  iter_done;

    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH-1:0] mul_hi_nxt;
    logic [DATA_WIDTH-1:0] mul_lo_nxt;

    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH:0]   div_trial;
    logic                  div_ok;
    logic [DATA_WIDTH-1:0] div_hi_nxt;
    logic [DATA_WIDTH-1:0] div_lo_nxt;

    logic [DATA_WIDTH-1:0] iter_hi_nxt;
    logic [DATA_WIDTH-1:0] iter_lo_nxt;
    logic [DATA_WIDTH-1:0] iter_result;

    assign in_ready_o    = (state == S_IDLE);
    assign is_mul_op     = (ALUctrl == OP_MUL) || (ALUctrl == OP_MULHU);
    assign is_div_op     = ((ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU))
                           && (ALUop2 != '0);
    assign single_accept = accept && !is_mul_op && !is_div_op;
    assign iter_done     = (state != S_IDLE) && (cnt == CNT_WIDTH'(1));

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole register right,
    // pulling the carry in at the top.
    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign mul_hi_nxt = mul_sum[DATA_WIDTH:1];
    assign mul_lo_nxt = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};

    // One restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not borrow.
    assign div_shift  = {acc_hi, acc_lo[DATA_WIDTH-1]};
    assign div_trial  = div_shift - {1'b0, opb};
    assign div_ok     = !div_trial[DATA_WIDTH];
    assign div_hi_nxt = div_ok ? div_trial[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
    assign div_lo_nxt = {acc_lo[DATA_WIDTH-2:0], div_ok};

    // Select the step result of whichever iterative unit is running.
    always_comb begin
        iter_hi_nxt = mul_hi_nxt;
        iter_lo_nxt = mul_lo_nxt;
        if (state == S_DIV) begin
            iter_hi_nxt = div_hi_nxt;
            iter_lo_nxt = div_lo_nxt;
        end
    end

    assign iter_result = want_hi ? iter_hi_nxt : iter_lo_nxt;

    // Sequencer: capture operands on accept and run DATA_WIDTH iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the accumulators are reset too, so an aborted operation leaves
        // no stale partial product or remainder behind.
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opb     <= '0;
            want_hi <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mul_op) begin
                        state   <= S_MUL;
                        cnt     <= CNT_WIDTH'(DATA_WIDTH);
                        acc_hi  <= '0;
                        acc_lo  <= ALUop2;
                        opb     <= ALUop1;
                        want_hi <= (ALUctrl == OP_MULHU);
                    end else if (accept && is_div_op) begin
                        state   <= S_DIV;
                        cnt     <= CNT_WIDTH'(DATA_WIDTH);
                        acc_hi  <= '0;
                        acc_lo  <= ALUop1;
                        opb     <= ALUop2;
                        want_hi <= (ALUctrl == OP_REMU);
                    end
                end
                S_MUL, S_DIV: begin
                    acc_hi <= iter_hi_nxt;
                    acc_lo <= iter_lo_nxt;
                    cnt    <= cnt - CNT_WIDTH'(1);
                    if (iter_done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`else

    assign in_ready_o    = 1'b1;
    assign single_accept = accept;

`endif

    // Result register: single-cycle results on accept, iterative results on
    // the last iteration; zero_o tracks the value written to ALUOut.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            ALUOut      <= '0;
            zero_o      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout sequential logic; the
            // default below makes out_valid_o a one-cycle pulse.
            out_valid_o <= 1'b0;
            if (single_accept) begin
                out_valid_o <= 1'b1;
                ALUOut      <= single_result;
                zero_o      <= (single_result == '0);
            end
`ifdef SEQ_ALU_MULDIV_EN
            else if (iter_done) begin
                out_valid_o <= 1'b1;
                ALUOut      <= iter_result;
                zero_o      <= (iter_result == '0);
            end
`endif
        end
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the RV32 datapath and the next generation of the single-cycle ALU. Single-cycle integer ops plus iterative multi-cycle unsigned multiply and divide sit behind a valid/ready handshake. The block sits in the execute stage. The control unit issues an operation and stalls the pipeline while `in_ready_o` is low.

## Interface
- `DATA_WIDTH`, 32: operand/result width; must be ≥ 4.
- `CNT_WIDTH`, $clog2(DATA_WIDTH)+1: iteration counter width.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: operation request.
- `in_ready_o` out 1: block can accept a request.
- `ALUop1` in DATA_WIDTH: operand A.
- `ALUop2` in DATA_WIDTH: operand B.
- `ALUctrl` in 4: operation code.
- `out_valid_o` out 1: one-cycle pulse; result is valid.
- `ALUOut` out DATA_WIDTH: registered result; held until the next completion.
- `zero_o` out 1: registered; high when `ALUOut == 0`.

## Operation
- Accept occurs on a rising edge where `in_valid_i && in_ready_o`. Operands and op are captured at accept. Later input changes are ignored.
- Op codes:
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT (signed)
  - 6 SLTU
  - 7 SLL
  - 8 SRL
  - 9 SRA
  - 10 MUL (low DATA_WIDTH bits of the product)
  - 11 MULHU (high DATA_WIDTH bits, unsigned)
  - 12 DIVU
  - 13 REMU
  - 14 and 15: treated as ADD.
- Shift amount is `ALUop2[$clog2(DATA_WIDTH)-1:0]`. Upper bits are ignored.
- SLT/SLTU return 1 or 0, zero-extended.
- All arithmetic wraps modulo 2^DATA_WIDTH.
- FSM states are IDLE, MUL, DIV.
  - IDLE: `in_ready_o`=1. On accept, ops 0–9 and 14–15 compute and register the result directly and stay in IDLE. MUL/MULHU go to MUL. DIVU/REMU go to DIV, except in the divide-by-zero case.
  - MUL: radix-2 shift-add, one bit per cycle, 2·DATA_WIDTH-bit accumulator, DATA_WIDTH iterations, then back to IDLE.
  - DIV: restoring shift-subtract, one quotient bit per cycle, DATA_WIDTH iterations, then back to IDLE.
- Divide by zero does not enter DIV. It completes as a single-cycle op: DIVU returns all-ones, REMU returns `ALUop1`.
- `in_ready_o` is 0 in MUL and DIV. A request presented then is not accepted; the requester holds it.
- `zero_o` is updated in the same cycle as `ALUOut`.

## Timing
- Reset (async assert, sync release): state IDLE, `in_ready_o`=1, `out_valid_o`=0, `ALUOut`=0, `zero_o`=1, counter 0, accumulators 0.
- Single-cycle ops and divide-by-zero: accept at edge N; `out_valid_o` high and `ALUOut` valid in the cycle after edge N.
- Back-to-back single-cycle ops sustain one result per cycle.
- MUL/MULHU/DIVU/REMU: accept at edge N; `out_valid_o` high for one cycle after edge N+DATA_WIDTH, i.e. latency DATA_WIDTH+1 edges.
- `in_ready_o` returns to 1 in that same completion cycle, so a new accept can coincide with the completion pulse.
- Reset asserted mid-operation aborts the operation immediately. No `out_valid_o` is produced for it.

## Configuration
- `SEQ_ALU_MULDIV_EN` defined: MUL and DIV states, the iterative datapath and op codes 10–13 are implemented as described.
- Not defined: no MUL/DIV logic is compiled.
  - Op codes 10–13 complete as single-cycle ops with `ALUOut`=0 and `zero_o`=1.
  - `in_ready_o` is tied to 1.

## Test plan
- Reset, then idle: `ALUOut`=0, `zero_o`=1, `in_ready_o`=1, `out_valid_o`=0.
- Back-to-back single-cycle ops:
  - SUB 5−5 → `ALUOut`=0, `zero_o`=1, one cycle after accept.
  - SLT with op1=0xFFFFFFFF, op2=1 → 1.
  - SLTU with the same operands → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001. MULHU with the same operands → 0xFFFFFFFE. Each pulses `out_valid_o` exactly 33 cycles after accept, with `in_ready_o`=0 throughout.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU x/0 → 0xFFFFFFFF in 1 cycle. REMU 9/0 → 9 in 1 cycle.
- Request held during DIV busy: not accepted until the completion cycle, then accepted. Its result follows with no lost or duplicated `out_valid_o` pulses.
- `rst_n` pulsed low at cycle 10 of a MUL: outputs return to reset values immediately, no `out_valid_o` for the aborted op, and a new ADD 2+3 → 5 after release.
